fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting upstream of the decoder: it owns the fetch PC, issues word requests to a multi-cycle instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small queue. Decode consumes {inst, inst_pc} over a valid/ready handshake. A taken branch or jump from execute redirects the fetch PC and flushes the queue, including any in-flight response.

## Interface
- DEPTH, 2, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  word address of request; stable while imem_req
- imem_ack  in  1  memory accepts request and returns imem_rdata this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  32  new fetch address, valid with redirect
- inst_valid  out  1  queue head holds an instruction
- inst  out  32  instruction at queue head
- inst_pc  out  32  PC of inst
- inst_ready  in  1  decode accepts head this cycle

## Operation
- State: fetch_pc (32b), queue (DEPTH × {pc, inst}), count (0..DEPTH), FSM {IDLE, REQ, DROP}.
- imem_req = (state==REQ || state==DROP); imem_addr = address latched at request start (req_addr).
- pop = inst_valid && inst_ready && !redirect; push = imem_ack && state==REQ && !redirect.
- IDLE: if count < DEPTH → REQ, req_addr <= fetch_pc.
- REQ without ack: hold. REQ with ack: push {req_addr, imem_rdata}; fetch_pc <= fetch_pc+4; if count+1-pop < DEPTH stay REQ with req_addr <= fetch_pc+4, else IDLE.
- DROP: hold req/addr until ack; discard imem_rdata; on ack → IDLE.
- redirect (any state): count <= 0, fetch_pc <= redirect_pc, no push, no pop. If REQ/DROP and no ack this cycle → DROP; otherwise → IDLE (response discarded).
- redirect while in DROP: update fetch_pc, remain DROP until ack.
- PC arithmetic mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Low two address bits are passed through unchecked.
- Queue is circular, head/tail pointers wrap at DEPTH; outputs come from registered storage.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0, fetch_pc RESET_PC, count 0, state IDLE.
- First imem_req rises in the cycle after the first clk edge with rst_n high.
- Memory latency: ack may arrive in the same cycle as req (zero wait) or any later cycle; only one request is ever outstanding.
- Ack at edge N → inst_valid high from cycle N+1.
- Zero-wait memory with inst_ready held 1 → one instruction per cycle after the first.
- Head {inst, inst_pc} stable while inst_valid && !inst_ready.
- Full queue (count==DEPTH): no request issued; pop at edge N → IDLE→REQ at N+1 (one-bubble refill).
- Simultaneous push and pop: count unchanged.
- Redirect at edge N: inst_valid 0 from N+1; the first post-redirect request is at N+1 (IDLE path) or after the pending ack (DROP path).
- rst_n low mid-request: all state cleared immediately; any later ack is ignored until a new request.

## Test plan
- Reset then zero-wait memory returning addr-derived words, inst_ready=1 → inst_pc 0,4,8,12 on consecutive cycles, inst_valid continuous from cycle 2.
- inst_ready=0 with DEPTH=2 → exactly two acks (PCs 0,4), imem_req drops; raise ready → PC 0 then 4 pop, fetch of 8 resumes one cycle after first pop.
- Memory with 3 wait states → imem_addr held for 4 cycles per request, each instruction delivered 1 cycle after ack, no duplicates.
- redirect to 32'h100 while request for 8 is pending without ack → queue empties next cycle, imem_addr stays 8 until ack, word discarded, next request addr 32'h100, first delivered inst_pc 32'h100.
- redirect to 32'h40 in same cycle as ack and pop → nothing pushed or popped, next request addr 32'h40.
- rst_n pulsed low mid-wait → imem_req 0 immediately, inst_valid 0, refetch starts at RESET_PC; fetch from 32'hFFFF_FFFC wraps next to 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, requests words from imem, and queues {pc, inst} for decode.
// Latency: a word acked at edge N is presented on inst/inst_pc from cycle N+1; zero-wait memory sustains 1 inst/cycle.
// Backpressure: when the queue is full no request is issued; refill restarts one cycle after the first pop.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic [31:0]   fetch_pc_inc;

  logic [31:0]   q_inst [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic          push;
  logic          pop;

  // A request stays visible (with a frozen address) until the memory acks it,
  // even when its response is going to be thrown away.
  assign imem_req     = (state == S_REQ) || (state == S_DROP);
  assign imem_addr    = req_addr;

  assign inst_valid   = (count != '0);
  assign inst         = q_inst[head];
  assign inst_pc      = q_pc[head];

  // Redirect wins over both queue operations: the whole queue is dead anyway.
  assign pop          = inst_valid && inst_ready && !redirect;
  assign push         = imem_ack && (state == S_REQ) && !redirect;

  assign count_next   = count + CW'(push) - CW'(pop);
  assign fetch_pc_inc = fetch_pc + 32'd4;

  // Fetch FSM, fetch PC and the address of the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      // An un-acked request cannot be withdrawn, so wait it out in DROP;
      // if it is acked right now its data is simply not pushed.
      if (((state == S_REQ) || (state == S_DROP)) && !imem_ack) begin
        state <= S_DROP;
      end else begin
        state <= S_IDLE;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (count < CW'(DEPTH)) begin
            state    <= S_REQ;
            req_addr <= fetch_pc;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            fetch_pc <= fetch_pc_inc;
            // Only chain the next request if its word will have a slot.
            if (count_next < CW'(DEPTH)) begin
              req_addr <= fetch_pc_inc;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Circular instruction queue; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_inst[tail] <= imem_rdata;
        q_pc[tail]   <= req_addr;
        tail         <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks   = 0;
  int failures = 0;

  // Memory responder: ack after `waits` stall cycles, gated by mem_en.
  int waits    = 0;
  bit mem_en   = 1'b1;
  int wcnt     = 0;
  int ack_cnt  = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign imem_ack   = mem_en && imem_req && (wcnt >= waits);
  assign imem_rdata = imem_ack ? word(imem_addr) : 32'h0;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
    if (imem_ack) ack_cnt <= ack_cnt + 1;
  end

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  // Holds reset for two cycles and releases it at a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %h want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %h want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h want 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", inst_pc); end
  endtask

  task automatic test_stream();
    waits = 0; mem_en = 1'b1; inst_ready = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stream_first_req: got %h want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL stream_first_addr: got %h want 0", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid: got %h want 0", inst_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %h want 1", k, inst_valid); end
      checks++; if (inst_pc !== 32'(4 * k)) begin failures++; $display("FAIL stream_pc[%0d]: got %h want %h", k, inst_pc, 32'(4 * k)); end
      checks++; if (inst !== word(32'(4 * k))) begin failures++; $display("FAIL stream_inst[%0d]: got %h want %h", k, inst, word(32'(4 * k))); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    waits = 0; mem_en = 1'b1; inst_ready = 1'b0;
    do_reset();
    base = ack_cnt;
    @(negedge clk); // c1: request 0 acked
    @(negedge clk); // c2: request 4 acked, head pc 0
    checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL bp_addr4: got %h want 4", imem_addr); end
    @(negedge clk); // c3: queue full
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_drop: got %h want 0", imem_req); end
    @(negedge clk); // c4: still stalled, head stable
    checks++; if ((ack_cnt - base) !== 2) begin failures++; $display("FAIL bp_ack_count: got %0d want 2", ack_cnt - base); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_held_low: got %h want 0", imem_req); end
    checks++; if (inst_pc !== 32'h0 || inst !== word(32'h0) || inst_valid !== 1'b1) begin
      failures++; $display("FAIL bp_head_stable: got v=%h pc=%h want v=1 pc=0", inst_valid, inst_pc); end
    inst_ready = 1'b1;
    @(negedge clk); // pc 0 popped; one bubble before refill
    checks++; if (inst_pc !== 32'h4 || inst_valid !== 1'b1) begin failures++; $display("FAIL bp_pop2: got v=%h pc=%h want v=1 pc=4", inst_valid, inst_pc); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_bubble: got %h want 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL bp_refill: got req=%h addr=%h want req=1 addr=8", imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL bp_empty: got %h want 0", inst_valid); end
    @(negedge clk);
    checks++; if (inst_pc !== 32'h8 || inst_valid !== 1'b1) begin failures++; $display("FAIL bp_pc8: got v=%h pc=%h want v=1 pc=8", inst_valid, inst_pc); end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp_addr;
    logic        exp_valid;
    waits = 3; mem_en = 1'b1; inst_ready = 1'b1;
    do_reset();
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      exp_addr  = 32'(((j - 1) / 4) * 4);
      exp_valid = (j == 5) || (j == 9);
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        failures++; $display("FAIL ws_addr[%0d]: got req=%h addr=%h want req=1 addr=%h", j, imem_req, imem_addr, exp_addr); end
      checks++; if (inst_valid !== exp_valid) begin failures++; $display("FAIL ws_valid[%0d]: got %h want %h", j, inst_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (inst_pc !== 32'(((j - 1) / 4 - 1) * 4)) begin
          failures++; $display("FAIL ws_pc[%0d]: got %h want %h", j, inst_pc, 32'(((j - 1) / 4 - 1) * 4)); end
      end
    end
    waits = 0;
  endtask

  task automatic test_redirect_pending();
    waits = 0; mem_en = 1'b1; inst_ready = 1'b1;
    do_reset();
    @(negedge clk); // c1 addr 0
    @(negedge clk); // c2 addr 4
    @(negedge clk); // c3 addr 8, not acked from here on
    checks++; if (imem_addr !== 32'h8 || inst_pc !== 32'h4) begin failures++; $display("FAIL rp_setup: got addr=%h pc=%h want addr=8 pc=4", imem_addr, inst_pc); end
    mem_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rp_flush: got %h want 0", inst_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL rp_hold1: got req=%h addr=%h want req=1 addr=8", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL rp_hold2: got req=%h addr=%h want req=1 addr=8", imem_req, imem_addr); end
    mem_en = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rp_discard: got req=%h v=%h want req=0 v=0", imem_req, inst_valid); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL rp_newreq: got req=%h addr=%h want req=1 addr=100", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== word(32'h100)) begin
      failures++; $display("FAIL rp_deliver: got v=%h pc=%h inst=%h want v=1 pc=100 inst=%h", inst_valid, inst_pc, inst, word(32'h100)); end
  endtask

  task automatic test_redirect_ack();
    waits = 0; mem_en = 1'b1; inst_ready = 1'b1;
    do_reset();
    @(negedge clk); // c1
    @(negedge clk); // c2: ack for 4 and pop of 0 both pending
    checks++; if (inst_valid !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL ra_setup: got v=%h addr=%h want v=1 addr=4", inst_valid, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL ra_flush: got v=%h req=%h want v=0 req=0", inst_valid, imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL ra_newreq: got req=%h addr=%h want req=1 addr=40", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (inst_pc !== 32'h40 || inst_valid !== 1'b1) begin failures++; $display("FAIL ra_deliver: got v=%h pc=%h want v=1 pc=40", inst_valid, inst_pc); end
  endtask

  task automatic test_reset_mid_and_wrap();
    waits = 3; mem_en = 1'b1; inst_ready = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rm_waiting: got %h want 1", imem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL rm_async: got req=%h v=%h want 0 0", imem_req, inst_valid); end
    @(negedge clk);
    waits = 0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rm_refetch: got req=%h addr=%h want req=1 addr=0", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (inst_pc !== 32'h0 || inst_valid !== 1'b1) begin failures++; $display("FAIL rm_pc0: got v=%h pc=%h want v=1 pc=0", inst_valid, inst_pc); end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req: got %h want fffffffc", imem_addr); end
    @(negedge clk);
    checks++; if (inst_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next: got pc=%h addr=%h want pc=fffffffc addr=0", inst_pc, imem_addr); end
    @(negedge clk);
    checks++; if (inst_pc !== 32'h0 || inst !== word(32'h0) || inst_valid !== 1'b1) begin
      failures++; $display("FAIL wrap_pc0: got v=%h pc=%h inst=%h want v=1 pc=0", inst_valid, inst_pc, inst); end
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect_pending();
    test_redirect_ack();
    test_reset_mid_and_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
